// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // ceil(width * log10(2)); fixed-point log10(2) is exact enough for any practical width
    function automatic int bcd_digits_needed(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Valid/ready handshake bundle between a binary producer and a BCD consumer.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic                  overflow;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, bcd, neg, overflow
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, bcd, neg, overflow
    );
endinterface

// File: rtl/bin2bcd_seq_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift one bit in.
module bcd_dabble_step #(
    parameter int DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] digits_i,
    input  logic                shift_i,
    output logic [4*DIGITS-1:0] digits_o,
    output logic                shift_o
);
    logic [4*DIGITS-1:0] adj;

    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digits_i[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = digits_i[4*i +: 4] + 4'd3;
            else
                adj[4*i +: 4] = digits_i[4*i +: 4];
        end
        {shift_o, digits_o} = {adj, shift_i};
    end
endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter, one input bit per clock, valid/ready on both sides.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = bcd_digits_needed(WIDTH),
    parameter bit SIGNED = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W-1:0]   digits_q, digits_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic               neg_acc_q, neg_acc_d;

    logic [BCD_W-1:0]   step_digits;
    logic               step_out;
    logic [WIDTH-1:0]   mag_in;
    logic               neg_in;

    bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
        .digits_i (digits_q),
        .shift_i  (mag_q[WIDTH-1]),
        .digits_o (step_digits),
        .shift_o  (step_out)
    );

    // Negation stays WIDTH bits unsigned, so the most negative input maps to 2^(WIDTH-1).
    always_comb begin
        mag_in = bus.in_data;
        if (SIGNED && bus.in_data[WIDTH-1])
            mag_in = (~bus.in_data) + {{(WIDTH-1){1'b0}}, 1'b1};
        neg_in = SIGNED && bus.in_data[WIDTH-1] && (mag_in != '0);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        digits_d  = digits_q;
        mag_d     = mag_q;
        ovf_acc_d = ovf_acc_q;
        neg_acc_d = neg_acc_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d   = ST_SHIFT;
                    cnt_d     = '0;
                    digits_d  = '0;
                    mag_d     = mag_in;
                    ovf_acc_d = 1'b0;
                    neg_acc_d = neg_in;
                end
            end
            ST_SHIFT: begin
                cnt_d     = cnt_q + 1'b1;
                digits_d  = step_digits;
                mag_d     = {mag_q[WIDTH-2:0], 1'b0};
                ovf_acc_d = ovf_acc_q | step_out;
                // Results capture the final step directly so DONE starts right after the last shift.
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    bcd_d   = step_digits;
                    neg_d   = neg_acc_q;
                    ovf_d   = ovf_acc_q | step_out;
                end
            end
            ST_DONE: begin
                if (bus.out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            bcd_q       <= '0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            bcd_q       <= bcd_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        digits_q  <= digits_d;
        mag_q     <= mag_d;
        ovf_acc_q <= ovf_acc_d;
        neg_acc_q <= neg_acc_d;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.bcd       = bcd_q;
    assign bus.neg       = neg_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: four configurations, table vectors, scoreboard and corner sequences.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] bcd;
        logic        neg;
        logic        ovf;
    } exp_t;

    typedef struct {
        int          cfg;
        logic [15:0] din;
        logic [19:0] bcd;
        logic        neg;
        logic        ovf;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    // cfg 0: 8b/3 digits, cfg 1: 8b/2 digits, cfg 2: 8b/3 digits signed, cfg 3: 16b/5 digits
    bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) if8  ();
    bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(2)) if2  ();
    bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) ifs  ();
    bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) if16 ();

    bin2bcd_seq #(.WIDTH(8),  .DIGITS(3), .SIGNED(1'b0)) u_d8  (.clk(clk), .reset(rst), .bus(if8));
    bin2bcd_seq #(.WIDTH(8),  .DIGITS(2), .SIGNED(1'b0)) u_d2  (.clk(clk), .reset(rst), .bus(if2));
    bin2bcd_seq #(.WIDTH(8),  .DIGITS(3), .SIGNED(1'b1)) u_ds  (.clk(clk), .reset(rst), .bus(ifs));
    bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_d16 (.clk(clk), .reset(rst), .bus(if16));

    function automatic int width_of(input int cfg);
        return (cfg == 3) ? 16 : 8;
    endfunction

    function automatic int digits_of(input int cfg);
        return (cfg == 1) ? 2 : ((cfg == 3) ? 5 : 3);
    endfunction

    // Arithmetic reference: magnitude, then decimal digits by division.
    function automatic exp_t model(input int cfg, input logic [15:0] din);
        exp_t   e;
        int     w = width_of(cfg);
        int     d = digits_of(cfg);
        longint mag, lim, r;
        logic   msb;
        mag = longint'(din) & ((longint'(1) << w) - 1);
        msb = din[w-1];
        if (cfg == 2 && msb) mag = (longint'(1) << w) - mag;
        e.neg = (cfg == 2) && msb && (mag != 0);
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        e.ovf = (mag >= lim);
        r = mag % lim;
        e.bcd = '0;
        for (int i = 0; i < d; i++) begin
            e.bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_asserts++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic set_in(input int cfg, input logic v, input logic [15:0] d);
        case (cfg)
            0:       begin if8.in_valid  = v; if8.in_data  = d[7:0]; end
            1:       begin if2.in_valid  = v; if2.in_data  = d[7:0]; end
            2:       begin ifs.in_valid  = v; ifs.in_data  = d[7:0]; end
            default: begin if16.in_valid = v; if16.in_data = d;      end
        endcase
    endtask

    task automatic set_ordy(input int cfg, input logic r);
        case (cfg)
            0:       if8.out_ready  = r;
            1:       if2.out_ready  = r;
            2:       ifs.out_ready  = r;
            default: if16.out_ready = r;
        endcase
    endtask

    task automatic sample(input int cfg, output logic ir, output logic ov,
                          output logic [19:0] b, output logic n, output logic o);
        case (cfg)
            0:       begin ir = if8.in_ready;  ov = if8.out_valid;  b = 20'(if8.bcd);  n = if8.neg;  o = if8.overflow;  end
            1:       begin ir = if2.in_ready;  ov = if2.out_valid;  b = 20'(if2.bcd);  n = if2.neg;  o = if2.overflow;  end
            2:       begin ir = ifs.in_ready;  ov = ifs.out_valid;  b = 20'(ifs.bcd);  n = ifs.neg;  o = ifs.overflow;  end
            default: begin ir = if16.in_ready; ov = if16.out_valid; b = 20'(if16.bcd); n = if16.neg; o = if16.overflow; end
        endcase
    endtask

    // Called and returns at a falling edge; the accepting rising edge lies inside.
    task automatic start(input int cfg, input logic [15:0] din, input bit push, input exp_t e);
        logic ir, ov, n, o;
        logic [19:0] b;
        int waitc = 0;
        sample(cfg, ir, ov, b, n, o);
        while (!ir && waitc < 200) begin
            @(negedge clk);
            waitc++;
            sample(cfg, ir, ov, b, n, o);
        end
        check("in_ready_before_accept", 32'(ir), 32'd1);
        set_in(cfg, 1'b1, din);
        if (push) sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        set_in(cfg, 1'b0, din);
    endtask

    task automatic finish(input int cfg, input string name, input bit rel);
        logic ir, ov, n, o;
        logic [19:0] b;
        exp_t e;
        int lat = 0;
        sample(cfg, ir, ov, b, n, o);
        while (!ov && lat < 200) begin
            @(negedge clk);
            lat++;
            sample(cfg, ir, ov, b, n, o);
        end
        check({name, "_latency"}, 32'(lat), 32'(width_of(cfg)));
        check({name, "_in_ready_low"}, 32'(ir), 32'd0);
        if (sb_q.size() == 0) begin
            check({name, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({name, "_bcd"}, 32'(b), 32'(e.bcd));
            check({name, "_neg"}, 32'(n), 32'(e.neg));
            check({name, "_overflow"}, 32'(o), 32'(e.ovf));
        end
        if (rel) begin
            set_ordy(cfg, 1'b1);
            @(posedge clk);
            @(negedge clk);
            set_ordy(cfg, 1'b0);
            sample(cfg, ir, ov, b, n, o);
            check({name, "_release_in_ready"}, 32'(ir), 32'd1);
            check({name, "_release_out_valid"}, 32'(ov), 32'd0);
        end
    endtask

    task automatic run(input int cfg, input logic [15:0] din, input exp_t e, input string name);
        start(cfg, din, 1'b1, e);
        finish(cfg, name, 1'b1);
    endtask

    initial begin
        logic ir, ov, n, o;
        logic [19:0] b;
        exp_t e;
        int seen;

        vecs.push_back('{0, 16'd0,     20'h00000, 1'b0, 1'b0});
        vecs.push_back('{0, 16'd9,     20'h00009, 1'b0, 1'b0});
        vecs.push_back('{0, 16'd10,    20'h00010, 1'b0, 1'b0});
        vecs.push_back('{0, 16'd99,    20'h00099, 1'b0, 1'b0});
        vecs.push_back('{0, 16'd100,   20'h00100, 1'b0, 1'b0});
        vecs.push_back('{0, 16'd255,   20'h00255, 1'b0, 1'b0});
        vecs.push_back('{1, 16'd255,   20'h00055, 1'b0, 1'b1});
        vecs.push_back('{1, 16'd99,    20'h00099, 1'b0, 1'b0});
        vecs.push_back('{2, 16'h0080,  20'h00128, 1'b1, 1'b0});
        vecs.push_back('{2, 16'h00FF,  20'h00001, 1'b1, 1'b0});
        vecs.push_back('{2, 16'h007F,  20'h00127, 1'b0, 1'b0});
        vecs.push_back('{2, 16'h0000,  20'h00000, 1'b0, 1'b0});
        vecs.push_back('{3, 16'd65535, 20'h65535, 1'b0, 1'b0});
        vecs.push_back('{3, 16'd10000, 20'h10000, 1'b0, 1'b0});
        vecs.push_back('{3, 16'd9999,  20'h09999, 1'b0, 1'b0});

        for (int c = 0; c < 4; c++) begin
            set_in(c, 1'b0, 16'd0);
            set_ordy(c, 1'b0);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            sample(c, ir, ov, b, n, o);
            check("reset_in_ready", 32'(ir), 32'd1);
            check("reset_out_valid", 32'(ov), 32'd0);
            check("reset_bcd", 32'(b), 32'd0);
            check("reset_neg", 32'(n), 32'd0);
            check("reset_overflow", 32'(o), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            e.bcd = vecs[i].bcd;
            e.neg = vecs[i].neg;
            e.ovf = vecs[i].ovf;
            run(vecs[i].cfg, vecs[i].din, e, "table");
        end

        // Backpressure: result held for 20 cycles, a stray in_valid pulse must be dropped.
        e.bcd = 20'h00077; e.neg = 1'b0; e.ovf = 1'b0;
        start(0, 16'd77, 1'b1, e);
        finish(0, "bp", 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (k == 5) set_in(0, 1'b1, 16'd5);
            if (k == 6) set_in(0, 1'b0, 16'd0);
            @(negedge clk);
            sample(0, ir, ov, b, n, o);
            check("bp_hold_bcd", 32'(b), 32'h77);
            check("bp_hold_out_valid", 32'(ov), 32'd1);
            check("bp_hold_in_ready", 32'(ir), 32'd0);
        end
        set_ordy(0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ordy(0, 1'b0);
        sample(0, ir, ov, b, n, o);
        check("bp_release_in_ready", 32'(ir), 32'd1);
        check("bp_release_out_valid", 32'(ov), 32'd0);
        check("bp_release_bcd_kept", 32'(b), 32'h77);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            sample(0, ir, ov, b, n, o);
            if (ov) seen++;
        end
        check("bp_stray_pulse_ignored", 32'(seen), 32'd0);

        // Reset during the fourth shift cycle discards the conversion.
        start(0, 16'd200, 1'b0, e);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sample(0, ir, ov, b, n, o);
        check("midreset_in_ready", 32'(ir), 32'd1);
        check("midreset_out_valid", 32'(ov), 32'd0);
        check("midreset_bcd", 32'(b), 32'd0);
        check("midreset_neg", 32'(n), 32'd0);
        check("midreset_overflow", 32'(o), 32'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            sample(0, ir, ov, b, n, o);
            if (ov) seen++;
        end
        check("midreset_no_result", 32'(seen), 32'd0);
        e.bcd = 20'h00123; e.neg = 1'b0; e.ovf = 1'b0;
        run(0, 16'd123, e, "after_reset");

        for (int v = 0; v < 65536; v += 29)
            run(3, 16'(v), model(3, 16'(v)), "sweep16");
        for (int v = 0; v < 256; v += 7) begin
            run(1, 16'(v), model(1, 16'(v)), "sweep8d2");
            run(2, 16'(v), model(2, 16'(v)), "sweep8s");
        end

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
